// File: rtl/stoch_bit_counter.sv
// Per-element ones counter for one stochastic bitstream.
// Synchronous clear wins over enable; the parent guarantees the count stays <= WINDOW.
module stoch_bit_counter #(
    parameter int COUNT_WIDTH = 9
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   clr,
    input  logic                   en,
    input  logic                   bit_in,
    output logic [COUNT_WIDTH-1:0] count
);

    logic [COUNT_WIDTH-1:0] count_q;

    assign count = count_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + {{(COUNT_WIDTH-1){1'b0}}, bit_in};
        end
    end

endmodule

// File: rtl/stoch_matrix_decode.sv
// Decodes a row-major matrix of stochastic bitstreams into per-element ones counts
// over a 2^WINDOW_LOG2-cycle window, holding the result under valid/ready.
module stoch_matrix_decode #(
    parameter int NUM_ROWS    = 2,
    parameter int NUM_COLS    = 2,
    parameter int WINDOW_LOG2 = 8,
    localparam int COUNT_WIDTH = WINDOW_LOG2 + 1,
    localparam int NUM_ELEMS   = NUM_ROWS * NUM_COLS
) (
    input  logic                             CLK,
    input  logic                             nRST,
    input  logic                             start,
    input  logic [NUM_ELEMS-1:0]             Y,
    output logic                             busy,
    output logic                             valid,
    input  logic                             ready,
    output logic [NUM_ELEMS*COUNT_WIDTH-1:0] counts
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]                              state_q;
    logic [WINDOW_LOG2-1:0]                  cyc_q;
    logic                                    busy_q;
    logic                                    valid_q;
    logic [NUM_ELEMS-1:0][COUNT_WIDTH-1:0]   counts_q;
    logic [NUM_ELEMS-1:0][COUNT_WIDTH-1:0]   counts_d;
    logic [NUM_ELEMS-1:0][COUNT_WIDTH-1:0]   acc;
    logic                                    acc_clr;
    logic                                    acc_en;
    logic                                    last_sample;

    assign acc_clr     = (state_q == S_IDLE) && start;
    assign acc_en      = (state_q == S_ACCUM);
    assign last_sample = (cyc_q == '1);

    genvar g;
    generate
        for (g = 0; g < NUM_ELEMS; g++) begin : g_elem
            stoch_bit_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_cnt (
                .CLK    (CLK),
                .nRST   (nRST),
                .clr    (acc_clr),
                .en     (acc_en),
                .bit_in (Y[g]),
                .count  (acc[g])
            );
        end
    endgenerate

    // The accumulators lag the final sample by one edge, so fold it in here.
    always_comb begin
        counts_d = '0;
        for (int k = 0; k < NUM_ELEMS; k++) begin
            counts_d[k] = acc[k] + {{(COUNT_WIDTH-1){1'b0}}, Y[k]};
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= S_IDLE;
            cyc_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            counts_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_ACCUM;
                        cyc_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    cyc_q <= cyc_q + 1'b1;
                    if (last_sample) begin
                        state_q  <= S_DONE;
                        busy_q   <= 1'b0;
                        valid_q  <= 1'b1;
                        counts_q <= counts_d;
                    end
                end
                S_DONE: begin
                    if (ready) begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign valid  = valid_q;
    assign counts = counts_q;

endmodule

// File: tb/tb_stoch_matrix_decode.sv
// Directed bench for stoch_matrix_decode (2x2, WINDOW=16) with a transaction-level model.
module tb_stoch_matrix_decode;

    localparam int NE = 4;
    localparam int CW = 5;
    localparam int WIN = 16;

    logic           CLK = 1'b0;
    logic           nRST;
    logic           start;
    logic [NE-1:0]  Y;
    logic           busy;
    logic           valid;
    logic           ready;
    logic [NE*CW-1:0] counts;

    int total = 0;
    int bad   = 0;

    stoch_matrix_decode #(.NUM_ROWS(2), .NUM_COLS(2), .WINDOW_LOG2(4)) dut (
        .CLK    (CLK),
        .nRST   (nRST),
        .start  (start),
        .Y      (Y),
        .busy   (busy),
        .valid  (valid),
        .ready  (ready),
        .counts (counts)
    );

    always #5 CLK = ~CLK;

    // Model: a window is "in progress" for WIN samples after an accepted start,
    // then the summed samples are held until a ready edge.
    bit m_inwin, m_done;
    int m_n;
    int sums [NE];
    int m_cnt[NE];

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_inwin <= 1'b0;
            m_done  <= 1'b0;
            m_n     <= 0;
            for (int k = 0; k < NE; k++) begin
                sums[k]  <= 0;
                m_cnt[k] <= 0;
            end
        end else if (m_done) begin
            if (ready) m_done <= 1'b0;
        end else if (m_inwin) begin
            for (int k = 0; k < NE; k++) sums[k] <= sums[k] + int'(Y[k]);
            m_n <= m_n + 1;
            if (m_n == WIN - 1) begin
                m_inwin <= 1'b0;
                m_done  <= 1'b1;
                for (int k = 0; k < NE; k++) m_cnt[k] <= sums[k] + int'(Y[k]);
            end
        end else if (start) begin
            m_inwin <= 1'b1;
            m_n     <= 0;
            for (int k = 0; k < NE; k++) sums[k] <= 0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int cnt(input int k);
        return int'(counts[k*CW +: CW]);
    endfunction

    always @(negedge CLK) begin
        if (nRST) begin
            check("model_busy", int'(busy), int'(m_inwin));
            check("model_valid", int'(valid), int'(m_done));
            for (int k = 0; k < NE; k++) check($sformatf("model_count%0d", k), cnt(k), m_cnt[k]);
        end
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    function automatic logic [NE-1:0] pat_y(input int pat, input int s);
        case (pat)
            0: return (s < 0) ? 4'h0 : {(s % 4 == 0), (s % 2 == 0), 1'b0, 1'b1};
            1: return (s == -1 || s == WIN - 1) ? 4'h1 : 4'h0;
            2: return 4'hF;
            3: return 4'h0;
            default: return 4'($urandom);
        endcase
    endfunction

    // Start a window and run until valid (bounded); lat counts edges after the start edge.
    task automatic win(input int pat, output int lat, output int bc);
        Y = pat_y(pat, -1);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        bc = busy ? 1 : 0;
        while (!valid && lat < 40) begin
            Y = pat_y(pat, lat);
            start = (pat == 5) && (lat == 3 || lat == 10);
            tick();
            lat++;
            if (busy) bc++;
        end
        start = 1'b0;
    endtask

    task automatic accept();
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

    int lat, bc, gap, nwin;
    bit seen_done;

    initial begin
        nRST = 1'b0; start = 1'b0; ready = 1'b0; Y = '0;
        tick(); tick();
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_counts", int'(counts), 0);
        nRST = 1'b1;
        tick();

        // Pattern decode
        win(0, lat, bc);
        check("s1_latency", lat, 16);
        check("s1_busy_cycles", bc, 16);
        check("s1_c0", cnt(0), 16);
        check("s1_c1", cnt(1), 0);
        check("s1_c2", cnt(2), 8);
        check("s1_c3", cnt(3), 4);
        accept();
        check("s1_valid_drop", int'(valid), 0);
        tick();

        // Last bit counted, start-edge bit not
        win(1, lat, bc);
        check("s2_c0", cnt(0), 1);
        accept();
        tick();

        // Backpressure
        win(0, lat, bc);
        for (int i = 0; i < 5; i++) begin
            Y = 4'($urandom);
            start = 1'b1;
            tick();
        end
        start = 1'b0;
        check("s3_valid_held", int'(valid), 1);
        check("s3_busy_held", int'(busy), 0);
        check("s3_c3", cnt(3), 4);
        check("s3_c2", cnt(2), 8);
        check("s3_c0", cnt(0), 16);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("s3_valid_drop", int'(valid), 0);
        tick();
        check("s3_no_restart", int'(busy), 0);

        // Reset mid-window
        Y = 4'hF; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        check("s4_busy_pre", int'(busy), 1);
        nRST = 1'b0;
        #1;
        check("s4_rst_busy", int'(busy), 0);
        check("s4_rst_valid", int'(valid), 0);
        check("s4_rst_counts", int'(counts), 0);
        #1;
        nRST = 1'b1;
        tick();
        win(2, lat, bc);
        check("s4_c0", cnt(0), 16);
        check("s4_c3", cnt(3), 16);
        accept();
        tick();

        // Back-to-back: ones then zeros, start in the IDLE cycle right after ready
        win(2, lat, bc);
        check("s5a_c1", cnt(1), 16);
        accept();
        win(3, lat, bc);
        check("s5b_latency", lat, 16);
        check("s5b_counts", int'(counts), 0);
        accept();

        // Continuous start: one IDLE observation between windows
        start = 1'b1; ready = 1'b1;
        seen_done = 1'b0; gap = 0; nwin = 0;
        for (int i = 0; i < 70; i++) begin
            Y = 4'($urandom);
            tick();
            if (valid) begin
                seen_done = 1'b1;
                gap = 0;
            end else if (!busy) begin
                if (seen_done) gap++;
            end else if (seen_done) begin
                check("s5_idle_gap", gap, 1);
                seen_done = 1'b0;
                nwin++;
            end
        end
        check("s5_windows", int'(nwin >= 3), 1);
        start = 1'b0;
        repeat (20) tick();
        ready = 1'b0;
        check("s5_drained", int'(busy | valid), 0);

        // start pulses mid-window are ignored
        win(5, lat, bc);
        check("s6_latency", lat, 16);
        check("s6_busy_cycles", bc, 16);
        accept();
        repeat (3) tick();
        check("s6_no_extra", int'(busy | valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stoch_matrix_decode.md
Name: stoch_matrix_decode

Overview:
Converts a row-major matrix of stochastic bitstreams into per-element binary counts over a fixed window of 2^WINDOW_LOG2 cycles. It sits at the output of the stochastic matrix multiplier array and turns each Y bitstream back into a fixed-point value, one window per start request. Results are held under a valid/ready handshake until the downstream binary logic accepts them.

Parameters:
NUM_ROWS, 2, matrix rows
NUM_COLS, 2, matrix columns
WINDOW_LOG2, 8, log2 of the sampling window length; WINDOW = 2^WINDOW_LOG2 cycles
(derived localparam) COUNT_WIDTH = WINDOW_LOG2+1, which holds the value WINDOW when a stream is all ones
(derived localparam) NUM_ELEMS = NUM_ROWS*NUM_COLS

Ports:
CLK  input  1  clock; all logic on the rising edge
nRST  input  1  asynchronous, active-low reset
start  input  1  request a new decode window; honoured only in IDLE
Y  input  NUM_ELEMS  bitstreams in row-major order; element (i,j) is on bit i*NUM_COLS+j
busy  output  1  high in ACCUM
valid  output  1  counts available
ready  input  1  downstream accepts counts
counts  output  NUM_ELEMS*COUNT_WIDTH  count for element k on counts[k*COUNT_WIDTH +: COUNT_WIDTH]

Behaviour:
- Reset (nRST low, asynchronous): state=IDLE, cycle counter=0, all accumulators=0, counts=0, valid=0, busy=0. A reset asserted mid-window aborts the window with no output.
- FSM states: IDLE, ACCUM, DONE.
- IDLE: on an edge with start=1, clear all accumulators and the cycle counter, then go to ACCUM. Y is not sampled on this edge.
- ACCUM: busy=1. On each edge, every accumulator k adds Y[k], and the cycle counter increments. On the WINDOW-th sampling edge (cycle counter = WINDOW-1):
  - counts[k] <= acc[k] + Y[k], so the final bit is included;
  - valid <= 1;
  - go to DONE.
- start is ignored in ACCUM and DONE.
- Latency: if start is sampled at edge 0, Y is sampled at edges 1..WINDOW and valid is high after edge WINDOW.
- DONE: valid=1 and counts are held stable. On an edge with ready=1: valid <= 0 and go to IDLE; counts keep their last value.
  - start coincident with the ready edge is ignored. A new window needs start in IDLE, so back-to-back windows have a minimum one-cycle IDLE gap.
- ready is don't-care outside DONE.
- Arithmetic: unsigned. An accumulator never exceeds WINDOW, so it cannot overflow at COUNT_WIDTH bits. The cycle counter is WINDOW_LOG2 bits and wraps to 0 on the final sample.
- Y is treated as synchronous to CLK; no input synchronizers.
- Value mapping (count/WINDOW is the unipolar probability) belongs downstream, not in this block.

Decomposition:
- No typedef package (plain Verilog). FSM state encodings are localparams local to this module. COUNT_WIDTH and NUM_ELEMS are derived localparams.
- One natural sub-module: stoch_bit_counter (parameter COUNT_WIDTH; ports CLK, nRST, clr, en, bit_in, count).
  - Instantiated NUM_ELEMS times in a generate loop, one per element.
  - The parent owns the FSM, the cycle counter, and the output registers.

Test Plan:
Use NUM_ROWS=2, NUM_COLS=2, WINDOW_LOG2=4 (WINDOW=16, COUNT_WIDTH=5) for all scenarios.
1. Pattern decode: Y[0]=1 constant, Y[1]=0 constant, Y[2] toggling 1010..., Y[3]=1 every 4th cycle; one start pulse -> valid rises exactly 16 edges after start; counts = {4, 8, 0, 16} for elements 3..0; busy high for 16 cycles.
2. Last-bit inclusion: Y[0]=1 only on the 16th sampling cycle, and Y[0]=1 on the start edge itself -> count0 = 1 (start-edge bit excluded, last bit included).
3. Backpressure: hold ready=0 for 5 cycles after valid, change Y randomly and pulse start -> counts unchanged, valid stays 1, no new window starts. Assert ready -> valid falls next edge and state returns to IDLE.
4. Reset mid-window: pulse nRST low asynchronously at sample 7 -> valid=0, busy=0, counts=0 immediately. A subsequent window with Y[0] all ones -> count0=16, showing no residue from the aborted window.
5. Back-to-back windows: assert start in the IDLE cycle right after ready, with different patterns (all ones, then all zeros) -> second result = 0 for every element. A start held high continuously yields windows separated by exactly one IDLE cycle.
6. Start ignored while busy: pulse start at sample 3 and sample 10 of a window -> exactly one valid per window; total latency unchanged.
